// File: rtl/ifid_buffer.sv
// rtl/ifid_buffer.sv - in-order IF/ID skid FIFO with RV32I predecode
//
// Optional feature: define IFID_BYPASS_EN to let a fetch beat pass straight
// to decode in the same cycle when the buffer is empty. Without it the
// buffer always adds one cycle and has no in_* -> out_* combinational path.

module ifid_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;

  logic stored_valid;
  logic bypass;
  logic push;
  logic pop;
  logic write_en;
  logic read_en;
  logic opcode_legal;

  // Bypass is only possible when nothing is queued, so ordering is preserved.
`ifdef IFID_BYPASS_EN
  assign bypass = reset_n & ~flush & in_valid & (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // Handshakes, head selection and the split of push/pop into storage actions.
  always_comb begin
    stored_valid = (cnt_q != '0);
    in_ready     = reset_n & (cnt_q != FULL) & ~flush;
    out_valid    = (stored_valid & ~flush) | bypass;
    out_pc       = bypass ? in_pc    : mem_pc[rd_ptr];
    out_instr    = bypass ? in_instr : mem_instr[rd_ptr];
    push         = in_valid & in_ready;
    pop          = out_valid & out_ready;
    // A bypassed beat taken by decode never touches storage.
    write_en     = push & ~(bypass & out_ready);
    read_en      = pop & ~bypass;
  end

  // Pointer and occupancy bookkeeping; flush wins over any handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (read_en)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, write_en} - {{AW{1'b0}}, read_en};
    end
  end

  // Payload storage, cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (!flush && write_en) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // Predecode of the presented instruction; illegal only flags a live beat.
  always_comb begin
    out_opcode = out_instr[6:0];
    out_rd     = out_instr[11:7];
    out_funct3 = out_instr[14:12];
    out_rs1    = out_instr[19:15];
    out_rs2    = out_instr[24:20];
    case (out_instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
      7'b0110011, 7'b0001111, 7'b1110011: opcode_legal = 1'b1;
      default:                            opcode_legal = 1'b0;
    endcase
    out_illegal = out_valid & ~opcode_legal;
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_ifid_buffer.sv
// tb/tb_ifid_buffer.sv - self-checking bench for ifid_buffer against a queue model

module tb_ifid_buffer;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic [6:0]        out_opcode;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [2:0]        out_funct3;
  logic              out_illegal;
  logic [$clog2(DEPTH):0] count;

  ifid_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] qpc[$];
  logic [31:0] qins[$];
  logic m_push, m_pop, m_byp, m_ready;

  logic [6:0] legal_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b0001111, 7'b1110011};

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 11; i++)
      if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model expectations for the current inputs, compared against every output.
  task automatic compare();
    int n;
    logic byp, ev, er;
    logic [31:0] hp, hi;
    if (!reset_n) begin
      qpc.delete();
      qins.delete();
    end
    n   = qpc.size();
    er  = reset_n && (n < DEPTH) && !flush;
    byp = BYP && reset_n && !flush && in_valid && (n == 0);
    ev  = ((n > 0) && !flush) || byp;
    hp  = byp ? in_pc    : ((n > 0) ? qpc[0]  : 32'h0);
    hi  = byp ? in_instr : ((n > 0) ? qins[0] : 32'h0);
    m_ready = er;
    m_push  = in_valid && er;
    m_pop   = ev && out_ready;
    m_byp   = byp;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    chk("count", count, n);
    chk("out_illegal", out_illegal, ev && !is_legal(hi[6:0]));
    if (ev) begin
      chk("out_pc", out_pc, hp);
      chk("out_instr", out_instr, hi);
      chk("out_opcode", out_opcode, hi[6:0]);
      chk("out_rd", out_rd, hi[11:7]);
      chk("out_rs1", out_rs1, hi[19:15]);
      chk("out_rs2", out_rs2, hi[24:20]);
      chk("out_funct3", out_funct3, hi[14:12]);
    end
    if (!reset_n) begin
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
    end
  endtask

  task automatic apply(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    reset_n = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    #1;
    compare();
  endtask

  // Advance one clock and let the model consume the beat it predicted.
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      if (flush) begin
        qpc.delete();
        qins.delete();
      end else if (!(m_byp && out_ready)) begin
        if (m_pop) begin
          void'(qpc.pop_front());
          void'(qins.pop_front());
        end
        if (m_push) begin
          qpc.push_back(in_pc);
          qins.push_back(in_instr);
        end
      end
    end
    @(negedge clk);
  endtask

  logic        hold;
  logic [31:0] hpc, hins, npc, rins;
  logic        rr, rf, riv, rordy;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset with a pending fetch beat.
    apply(0, 0, 1, 32'h40, 32'h13, 1);
    chk("lit_rst_in_ready", in_ready, 0);
    chk("lit_rst_out_valid", out_valid, 0);
    chk("lit_rst_count", count, 0);
    tick();
    apply(1, 0, 0, 32'h0, 32'h0, 0);
    chk("lit_post_rst_in_ready", in_ready, 1);
    tick();

    // Fill, stall a third beat, then drain in order.
    apply(1, 0, 1, 32'h0, 32'h13, 0); tick();
    apply(1, 0, 1, 32'h4, 32'h33, 0); tick();
    apply(1, 0, 1, 32'h8, 32'h37, 0);
    chk("lit_full_count", count, 2);
    chk("lit_full_in_ready", in_ready, 0);
    chk("lit_full_head", out_pc, 32'h0);
    tick();
    apply(1, 0, 1, 32'h8, 32'h37, 1);
    chk("lit_drain0", out_pc, 32'h0);
    tick();
    apply(1, 0, 1, 32'h8, 32'h37, 1);
    chk("lit_drain1", out_pc, 32'h4);
    chk("lit_third_ready", in_ready, 1);
    tick();
    apply(1, 0, 0, 32'h0, 32'h0, 1);
    chk("lit_drain2", out_pc, 32'h8);
    chk("lit_drain2_valid", out_valid, 1);
    tick();

    // Flush of a full buffer while a new beat is offered.
    apply(1, 0, 1, 32'h10, 32'h13, 0); tick();
    apply(1, 0, 1, 32'h14, 32'h13, 0); tick();
    apply(1, 1, 1, 32'h100, 32'h13, 0);
    chk("lit_flush_out_valid", out_valid, 0);
    tick();
    apply(1, 0, 0, 32'h0, 32'h0, 0);
    chk("lit_after_flush_count", count, 0);
    chk("lit_after_flush_valid", out_valid, 0);
    tick();

    // Predecode of a legal ADDI and of an all-ones word.
    apply(1, 0, 1, 32'h200, 32'h00500093, 0); tick();
    apply(1, 0, 0, 32'h0, 32'h0, 1);
    chk("lit_addi_opcode", out_opcode, 7'b0010011);
    chk("lit_addi_rd", out_rd, 1);
    chk("lit_addi_rs1", out_rs1, 0);
    chk("lit_addi_illegal", out_illegal, 0);
    tick();
    apply(1, 0, 1, 32'h204, 32'hFFFFFFFF, 0); tick();
    apply(1, 0, 0, 32'h0, 32'h0, 1);
    chk("lit_ones_illegal", out_illegal, 1);
    tick();

    // Same-cycle visibility only with the bypass build.
    apply(1, 0, 1, 32'h300, 32'h00000013, 1);
    chk("lit_byp_same_cycle", out_valid, BYP);
    tick();
    apply(1, 0, 0, 32'h0, 32'h0, 1);
    chk("lit_byp_next_valid", out_valid, !BYP);
    chk("lit_byp_next_count", count, BYP ? 0 : 1);
    tick();
    apply(1, 0, 0, 32'h0, 32'h0, 1); tick();

    // Streaming: ten back-to-back beats.
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 1, 32'(i * 4), 32'h13, 1);
      chk("lit_stream_count_le1", count <= 1, 1);
      tick();
    end
    apply(1, 0, 0, 32'h0, 32'h0, 1); tick();

    // Randomized traffic with flushes, resets and a well-behaved upstream.
    hold = 1'b0; hpc = '0; hins = '0; npc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      rr    = ($urandom_range(0, 99) != 0);
      rf    = ($urandom_range(0, 19) == 0);
      rordy = ($urandom_range(0, 2) != 0);
      if (hold) begin
        riv = 1'b1;
      end else begin
        riv  = ($urandom_range(0, 3) != 0);
        rins = $urandom();
        if ($urandom_range(0, 1) == 1)
          rins[6:0] = legal_ops[$urandom_range(0, 10)];
        hpc  = npc;
        hins = rins;
        npc  = npc + 4;
      end
      apply(rr, rf, riv, hpc, hins, rordy);
      hold = rr && !rf && riv && !m_ready;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_buffer.md
IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, number of storage entries (power of two, >=2).
REQ-002 SHALL provide parameter XLEN, default 32, width of PC and instruction.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_pc input XLEN, in_instr input XLEN: fetch-side handshake and payload.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_pc output XLEN, out_instr output XLEN: decode-side handshake and payload.
REQ-008 SHALL have predecode outputs out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_funct3 3, out_illegal 1: fields of the presented instruction.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-010 SHALL be an in-order FIFO between the fetch unit and decode; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-011 SHALL drive in_ready = (count < DEPTH) & ~flush, with no combinational path from out_ready.
REQ-012 SHALL drive out_valid = (count != 0) & ~flush when no bypass is active.
REQ-013 SHALL present the head entry on out_pc/out_instr with zero added latency; an entry pushed at edge N is visible from cycle N+1.
REQ-014 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-015 SHALL wrap read/write pointers modulo DEPTH.
REQ-016 SHALL, when full, refuse pushes (in_ready=0) while still allowing a pop; in_ready returns to 1 the cycle after the pop.
REQ-017 SHALL, when empty, hold out_valid=0 and ignore out_ready.
REQ-018 SHALL, on flush=1 at an edge, set count=0 and both pointers=0; flush overrides any push or pop in that cycle.
REQ-019 SHALL decode out_opcode=instr[6:0], out_rd=[11:7], out_funct3=[14:12], out_rs1=[19:15], out_rs2=[24:20] from the presented instruction.
REQ-020 SHALL assert out_illegal = out_valid & (opcode not in RV32I set {0110111,0010111,1101111,1100111,1100011,0000011,0100011,0010011,0110011,0001111,1110011}).
REQ-021 SHALL require upstream to hold in_pc/in_instr stable while in_valid=1 and in_ready=0; a payload is never dropped or duplicated.

Reset
REQ-022 SHALL, while reset_n=0, force count=0, pointers=0, storage=0, in_ready=0, out_valid=0, out_pc=0, out_instr=0, out_illegal=0.
REQ-023 SHALL assert in_ready=1 in the first cycle after reset_n rises (absent flush).
REQ-024 SHALL discard all stored entries when reset asserts mid-operation, including a partially accepted handshake.

Configuration
REQ-025 SHALL, with IFID_BYPASS_EN defined, when count=0 and in_valid=1 and flush=0, drive out_valid=1 and out_* directly from in_*, same cycle.
REQ-026 SHALL, in bypass with out_ready=1, consume the entry without storing it (count stays 0); with out_ready=0 the entry is stored normally.
REQ-027 SHALL, without IFID_BYPASS_EN, have no combinational path from in_* to out_*; minimum latency is one cycle.

Verification
REQ-028 Reset: reset_n=0 with in_valid=1 -> in_ready=0, out_valid=0, count=0; after release in_ready=1.
REQ-029 Fill/drain: push pc 0x0,0x4 with out_ready=0 -> count=2, in_ready=0; third push held; out_ready=1 -> pops 0x0 then 0x4, then held third entry accepted, order preserved.
REQ-030 Streaming: in_valid=out_ready=1 for 10 cycles, pc 0x0..0x24 -> each pc emitted exactly once in order, count stays <=1.
REQ-031 Flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, flushed-cycle input not stored.
REQ-032 Predecode: push 0x00500093 -> out_opcode=0010011, out_rd=1, out_rs1=0, out_illegal=0; push 0xFFFFFFFF -> out_illegal=1.
REQ-033 Bypass (IFID_BYPASS_EN): empty, in_valid=1, in_instr=0x00000013, out_ready=1 -> out_valid=1 same cycle, count stays 0; without macro out_valid=1 one cycle later.
